// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq : multi-cycle 8051 MUL AB / DIV AB sequencer (shift-add / restoring)
// Optional stall-cycle counter enabled by defining MULDIV_STALL_CNT_EN.
// Revision   : 1.0
// ============================================================================
module muldiv_seq #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [WIDTH-1:0]     o_res_a,
  output logic [WIDTH-1:0]     o_res_b,
  output logic                 o_cy,
  output logic                 o_ov,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);
  localparam int ITW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [ITW-1:0]     iter;
  logic               op;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [WIDTH:0]     rem, rem_nxt, rem_shift, rem_diff, mul_sum;
  logic [WIDTH-1:0]   quo, quo_nxt;
  logic [WIDTH-1:0]   res_a, res_b;
  logic               ov;
  logic               div_zero, last;

  assign div_zero = i_op && (i_b == '0);
  assign last     = (state == RUN) && (iter == '0);

  // Multiplier sits in the low half of prod and shifts out as the product shifts in.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : '0);
    prod_nxt  = {mul_sum, prod[WIDTH-1:1]};
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opb};
    if (rem_shift >= {1'b0, opb}) begin
      rem_nxt = rem_diff;
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_shift;
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = div_zero ? DONE : RUN;
      RUN:     if (iter == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      iter  <= '0;
      op    <= 1'b0;
      opb   <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      res_a <= '0;
      res_b <= '0;
      ov    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (i_start) begin
            op   <= i_op;
            opb  <= i_b;
            prod <= {{WIDTH{1'b0}}, i_a};
            rem  <= '0;
            quo  <= i_a;
            iter <= ITW'(WIDTH - 1);
            if (div_zero) begin
              res_a <= '1;
              res_b <= i_a;
              ov    <= 1'b1;
            end
          end
        end
        RUN: begin
          iter <= last ? '0 : iter - 1'b1;
          if (op) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
          end else begin
            prod <= prod_nxt;
          end
          if (last) begin
            if (op) begin
              res_a <= quo_nxt;
              res_b <= rem_nxt[WIDTH-1:0];
              ov    <= 1'b0;
            end else begin
              res_a <= prod_nxt[WIDTH-1:0];
              res_b <= prod_nxt[2*WIDTH-1:WIDTH];
              ov    <= |prod_nxt[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stall is combinational on i_start so the requesting instruction holds this cycle.
  assign o_stall = ~i_rst & (((state == IDLE) & i_start) | (state == RUN));
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_res_a = res_a;
  assign o_res_b = res_b;
  assign o_ov    = ov;
  assign o_cy    = 1'b0;

`ifdef MULDIV_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      stall_cnt <= '0;
    else if (o_stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
`default_nettype wire
